// File: rtl/fsb_mem_responder.sv
// fsb_mem_responder: memory-side responder on a snooped front-side bus.
// Accepts one bus operation at a time from the L2. Each operation runs a snoop
// window, then takes one of three paths: it collects a dirty line from a HITM
// owner, it accesses the backing store after a fixed DRAM latency, or it goes
// straight to the response (INVALIDATE). The response is held until the L2
// consumes it.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in idle)
//   req_op/req_addr/req_data        operation, line address, write line
//   snoop_result                    sampled only in the last snoop cycle
//   wb_valid/wb_data                dirty-line writeback from the HITM owner
//   rsp_valid/rsp_ready             response handshake
//   rsp_data/rsp_shared             returned line and the shared indication
module fsb_mem_responder #(
    parameter int unsigned ADDR_BITS    = 32,
    parameter int unsigned LINE_BITS    = 512,
    parameter int unsigned MEM_LINES    = 16,
    parameter int unsigned MEM_LATENCY  = 4,
    parameter int unsigned SNOOP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LINE_BITS-1:0] req_data,
    input  logic [1:0]           snoop_result,
    input  logic                 wb_valid,
    input  logic [LINE_BITS-1:0] wb_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LINE_BITS-1:0] rsp_data,
    output logic                 rsp_shared
);

    localparam int unsigned IdxBits = $clog2(MEM_LINES);

    localparam logic [2:0] OpRead  = 3'd1;
    localparam logic [2:0] OpWrite = 3'd2;
    localparam logic [2:0] OpRwim  = 3'd3;
    localparam logic [2:0] OpInval = 3'd4;

    localparam logic [7:0] SnoopLast = 8'(SNOOP_CYCLES - 1);
    localparam logic [7:0] WaitLast  = 8'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StSnoop, StWb, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [IdxBits-1:0]   idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_shared_q, rsp_shared_d;

    logic [LINE_BITS-1:0] mem_q [MEM_LINES];
    logic                 mem_we;
    logic [LINE_BITS-1:0] mem_wdata;

    // Only the line index field selects storage; other address bits alias.
    logic unused_addr;
    assign unused_addr = ^{req_addr[ADDR_BITS-1:6+IdxBits], req_addr[5:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rsp_data_d   = rsp_data_q;
        rsp_shared_d = rsp_shared_q;
        mem_we       = 1'b0;
        mem_wdata    = wdata_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid && req_op >= OpRead && req_op <= OpInval) begin
                    op_d    = req_op;
                    idx_d   = req_addr[6 +: IdxBits];
                    wdata_d = req_data;
                    cnt_d   = '0;
                    state_d = StSnoop;
                end
            end
            StSnoop: begin
                if (cnt_q == SnoopLast) begin
                    cnt_d        = '0;
                    rsp_shared_d = |snoop_result;
                    rsp_data_d   = '0;
                    if (op_q == OpInval) begin
                        state_d = StResp;
                    end else if (snoop_result == 2'b10 && (op_q == OpRead || op_q == OpRwim)) begin
                        state_d = StWb;
                    end else begin
                        state_d = StWait;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWb: begin
                // The owner's dirty line refreshes memory and is also the reply.
                if (wb_valid) begin
                    mem_we     = 1'b1;
                    mem_wdata  = wb_data;
                    rsp_data_d = wb_data;
                    state_d    = StResp;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    cnt_d = '0;
                    if (op_q == OpWrite) begin
                        mem_we = 1'b1;
                    end else begin
                        rsp_data_d = mem_q[idx_q];
                    end
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_data_d   = '0;
                    rsp_shared_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            op_q         <= '0;
            idx_q        <= '0;
            wdata_q      <= '0;
            rsp_data_q   <= '0;
            rsp_shared_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rsp_data_q   <= rsp_data_d;
            rsp_shared_q <= rsp_shared_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MEM_LINES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    assign rsp_data   = rsp_data_q;
    assign rsp_shared = rsp_shared_q;

endmodule

// File: tb/tb_fsb_mem_responder.sv
module tb_fsb_mem_responder;

    localparam int S = 2;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [31:0]  req_addr;
    logic [511:0] req_data;
    logic [1:0]   snoop_result;
    logic         wb_valid;
    logic [511:0] wb_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [511:0] rsp_data;
    logic         rsp_shared;

    int total = 0;
    int bad   = 0;

    logic [511:0] pat_a5;
    logic [511:0] pat_5a;
    logic [511:0] pat_33;

    int           lat;
    logic [511:0] d;
    logic         sh;

    fsb_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .snoop_result (snoop_result),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_shared   (rsp_shared)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for rsp_valid. Before the last snoop cycle the
    // snoop input carries a decoy HITM that must be ignored. wb_at >= 0 raises
    // wb_valid in the cycle lat == wb_at.
    task automatic transact(input logic [2:0] op, input logic [31:0] addr,
                            input logic [511:0] data, input logic [1:0] snp,
                            input int wb_at, input logic [511:0] wbd,
                            output int l, output logic [511:0] od, output logic osh);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        l = 0;
        while (!rsp_valid && l < 100) begin
            snoop_result = (l == S - 1) ? snp : 2'b10;
            if (l == wb_at) begin
                wb_valid = 1'b1;
                wb_data  = wbd;
            end
            @(posedge clk);
            #1;
            l++;
            wb_valid = 1'b0;
            wb_data  = '1;
        end
        snoop_result = 2'b00;
        od  = rsp_data;
        osh = rsp_shared;
    endtask

    task automatic handshake();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("rsp_valid_after_hs", 512'(rsp_valid), 512'(0));
        check_eq("req_ready_after_hs", 512'(req_ready), 512'(1));
    endtask

    initial begin
        pat_a5 = {64{8'hA5}};
        pat_5a = {64{8'h5A}};
        pat_33 = {64{8'h33}};
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_addr     = '0;
        req_data     = '0;
        snoop_result = 2'b00;
        wb_valid     = 1'b0;
        wb_data      = '0;
        rsp_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 512'(req_ready), 512'(1));
        check_eq("rst_rsp_valid", 512'(rsp_valid), 512'(0));
        check_eq("rst_rsp_data", rsp_data, 512'(0));
        check_eq("rst_rsp_shared", 512'(rsp_shared), 512'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // READ 0x40, NOHIT
        transact(3'd1, 32'h40, '0, 2'b00, -1, '0, lat, d, sh);
        check_eq("rd40_lat", 512'(lat), 512'(S + M));
        check_eq("rd40_data", d, 512'(0));
        check_eq("rd40_shared", 512'(sh), 512'(0));
        handshake();

        // WRITE 0x80 then READ 0x80 with HIT
        transact(3'd2, 32'h80, pat_a5, 2'b00, -1, '0, lat, d, sh);
        check_eq("wr80_lat", 512'(lat), 512'(S + M));
        check_eq("wr80_data", d, 512'(0));
        handshake();
        transact(3'd1, 32'h80, '0, 2'b01, -1, '0, lat, d, sh);
        check_eq("rd80_data", d, pat_a5);
        check_eq("rd80_shared", 512'(sh), 512'(1));
        handshake();

        // RWIM 0xC0 with HITM, writeback 3 cycles into WB
        transact(3'd3, 32'hC0, '0, 2'b10, S + 3, pat_5a, lat, d, sh);
        check_eq("rwim_lat", 512'(lat), 512'(S + 4));
        check_eq("rwim_data", d, pat_5a);
        check_eq("rwim_shared", 512'(sh), 512'(1));
        handshake();
        transact(3'd1, 32'hC0, '0, 2'b00, -1, '0, lat, d, sh);
        check_eq("rdC0_lat", 512'(lat), 512'(S + M));
        check_eq("rdC0_data", d, pat_5a);
        handshake();

        // INVALIDATE 0x80 with HIT leaves memory alone
        transact(3'd4, 32'h80, '0, 2'b01, -1, '0, lat, d, sh);
        check_eq("inv_lat", 512'(lat), 512'(S));
        check_eq("inv_data", d, 512'(0));
        check_eq("inv_shared", 512'(sh), 512'(1));
        handshake();

        // Aliased address 0x480 hits line index 2; snoop 11 counts as shared
        transact(3'd1, 32'h480, '0, 2'b11, -1, '0, lat, d, sh);
        check_eq("alias_data", d, pat_a5);
        check_eq("alias_shared", 512'(sh), 512'(1));
        handshake();

        // Backpressure with a pending request
        transact(3'd1, 32'hC0, '0, 2'b00, -1, '0, lat, d, sh);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_op    = 3'd1;
            req_addr  = 32'h40;
            @(posedge clk);
            #1;
            check_eq("bp_rsp_valid", 512'(rsp_valid), 512'(1));
            check_eq("bp_req_ready", 512'(req_ready), 512'(0));
            check_eq("bp_rsp_data", rsp_data, pat_5a);
        end
        handshake();
        req_valid = 1'b0;
        req_op    = 3'd0;
        @(posedge clk);
        #1;
        check_eq("bp_not_accepted", 512'(req_ready), 512'(1));

        // Reserved and NONE ops are ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd5;
        @(posedge clk);
        #1;
        check_eq("op5_ignored", 512'(req_ready), 512'(1));
        req_op = 3'd0;
        @(posedge clk);
        #1;
        check_eq("op0_ignored", 512'(req_ready), 512'(1));
        req_valid = 1'b0;

        // Reset during WAIT of WRITE 0x100
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_addr  = 32'h100;
        req_data  = pat_33;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        repeat (S + 1) @(posedge clk);
        #1;
        check_eq("mid_req_ready", 512'(req_ready), 512'(0));
        rst_n = 1'b0;
        #1;
        check_eq("arst_req_ready", 512'(req_ready), 512'(1));
        check_eq("arst_rsp_valid", 512'(rsp_valid), 512'(0));
        check_eq("arst_rsp_data", rsp_data, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        transact(3'd1, 32'h100, '0, 2'b00, -1, '0, lat, d, sh);
        check_eq("aborted_wr_data", d, 512'(0));
        handshake();
        transact(3'd1, 32'h80, '0, 2'b00, -1, '0, lat, d, sh);
        check_eq("mem_cleared", d, 512'(0));
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
